// File: rtl/light_pkg.sv
// Shared types and helpers for the traffic-light bus monitor.
// Phase codes match the decoded order RED -> YELLOW -> GREEN.
package light_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_RED     = 2'd0;
    localparam phase_t PH_YELLOW  = 2'd1;
    localparam phase_t PH_GREEN   = 2'd2;
    localparam phase_t PH_INVALID = 2'd3;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_TRACK  = 1'b1
    } state_t;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_RED:    n = PH_YELLOW;
            PH_YELLOW: n = PH_GREEN;
            PH_GREEN:  n = PH_RED;
            default:   n = PH_INVALID;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/light_decode.sv
// One-hot light bus to phase code decoder.
// Anything that is not exactly one-hot, including all-off, is INVALID.
module light_decode
    import light_pkg::*;
(
    input  logic   red_i,
    input  logic   yellow_i,
    input  logic   green_i,
    output phase_t phase_o
);

    always_comb begin
        phase_o = PH_INVALID;
        case ({red_i, yellow_i, green_i})
            3'b100:  phase_o = PH_RED;
            3'b010:  phase_o = PH_YELLOW;
            3'b001:  phase_o = PH_GREEN;
            default: phase_o = PH_INVALID;
        endcase
    end

endmodule

// File: rtl/light_monitor.sv
// Passive checker for the traffic-light sequencer bus: order,
// one-hot and dwell checks with sticky flags and a cycle counter.
module light_monitor
    import light_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_dwell,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] MAX_D   = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONE = '1;

    phase_t           cur;
    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic             locked_q, locked_d;
    logic             eoh_q, eoh_d;
    logic             eord_q, eord_d;
    logic             edw_q, edw_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dwell_inc;
    logic             set_oh, set_ord, set_dw;

    light_decode u_decode (
        .red_i    (red),
        .yellow_i (yellow),
        .green_i  (green),
        .phase_o  (cur)
    );

    assign dwell_inc = (dwell_q == ALL_ONE) ? dwell_q : dwell_q + ONE;

    always_comb begin
        state_d  = state_q;
        phase_d  = cur;
        locked_d = locked_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        set_oh   = 1'b0;
        set_ord  = 1'b0;
        set_dw   = 1'b0;
        case (state_q)
            ST_UNSYNC: begin
                if (cur == PH_INVALID) begin
                    set_oh = 1'b1;
                end else begin
                    state_d = ST_TRACK;
                    dwell_d = ONE;
                end
            end
            default: begin
                if (cur == PH_INVALID) begin
                    set_oh   = 1'b1;
                    state_d  = ST_UNSYNC;
                    locked_d = 1'b0;
                    dwell_d  = '0;
                end else if (cur == phase_q) begin
                    dwell_d = dwell_inc;
                    set_dw  = (dwell_inc > MAX_D);
                end else if (cur == next_phase(phase_q)) begin
                    locked_d = 1'b1;
                    dwell_d  = ONE;
                    if (phase_q == PH_GREEN && cnt_q != ALL_ONE)
                        cnt_d = cnt_q + ONE;
                end else begin
                    // Resynchronise on the unexpected phase
                    set_ord  = 1'b1;
                    locked_d = 1'b0;
                    dwell_d  = ONE;
                end
            end
        endcase
        eoh_d  = set_oh  | (eoh_q  & ~clr_err);
        eord_d = set_ord | (eord_q & ~clr_err);
        edw_d  = set_dw  | (edw_q  & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_UNSYNC;
            phase_q  <= PH_INVALID;
            locked_q <= 1'b0;
            eoh_q    <= 1'b0;
            eord_q   <= 1'b0;
            edw_q    <= 1'b0;
            dwell_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            locked_q <= locked_d;
            eoh_q    <= eoh_d;
            eord_q   <= eord_d;
            edw_q    <= edw_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = locked_q;
    assign err_onehot  = eoh_q;
    assign err_order   = eord_q;
    assign err_dwell   = edw_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor: default, MAX_DWELL=3 and CNT_W=2
// instances share one stimulus stream and are checked side by side.
module tb_light_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic red = 1'b1;
    logic yellow = 1'b0;
    logic green = 1'b0;
    logic clr_err = 1'b0;

    logic [1:0]  ph_a, ph_b, ph_c;
    logic        lk_a, lk_b, lk_c;
    logic        eoh_a, eoh_b, eoh_c;
    logic        eord_a, eord_b, eord_c;
    logic        edw_a, edw_b, edw_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    light_monitor u_a (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .clr_err(clr_err), .phase(ph_a), .locked(lk_a),
        .err_onehot(eoh_a), .err_order(eord_a), .err_dwell(edw_a),
        .cycle_count(cnt_a)
    );

    light_monitor #(.MAX_DWELL(3)) u_b (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .clr_err(clr_err), .phase(ph_b), .locked(lk_b),
        .err_onehot(eoh_b), .err_order(eord_b), .err_dwell(edw_b),
        .cycle_count(cnt_b)
    );

    light_monitor #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .clr_err(clr_err), .phase(ph_c), .locked(lk_c),
        .err_onehot(eoh_c), .err_order(eord_c), .err_dwell(edw_c),
        .cycle_count(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full comparison of all three instances after one sample
    task automatic expect_all(input string tag, input int ph, input int lk,
                              input int eoh, input int eord,
                              input int edwa, input int edwb, input int edwc,
                              input int cntab, input int cntc);
        chk({tag, ".a.phase"}, 32'(ph_a), 32'(ph));
        chk({tag, ".b.phase"}, 32'(ph_b), 32'(ph));
        chk({tag, ".c.phase"}, 32'(ph_c), 32'(ph));
        chk({tag, ".a.locked"}, 32'(lk_a), 32'(lk));
        chk({tag, ".b.locked"}, 32'(lk_b), 32'(lk));
        chk({tag, ".c.locked"}, 32'(lk_c), 32'(lk));
        chk({tag, ".a.err_onehot"}, 32'(eoh_a), 32'(eoh));
        chk({tag, ".b.err_onehot"}, 32'(eoh_b), 32'(eoh));
        chk({tag, ".c.err_onehot"}, 32'(eoh_c), 32'(eoh));
        chk({tag, ".a.err_order"}, 32'(eord_a), 32'(eord));
        chk({tag, ".b.err_order"}, 32'(eord_b), 32'(eord));
        chk({tag, ".c.err_order"}, 32'(eord_c), 32'(eord));
        chk({tag, ".a.err_dwell"}, 32'(edw_a), 32'(edwa));
        chk({tag, ".b.err_dwell"}, 32'(edw_b), 32'(edwb));
        chk({tag, ".c.err_dwell"}, 32'(edw_c), 32'(edwc));
        chk({tag, ".a.count"}, 32'(cnt_a), 32'(cntab));
        chk({tag, ".b.count"}, 32'(cnt_b), 32'(cntab));
        chk({tag, ".c.count"}, 32'(cnt_c), 32'(cntc));
    endtask

    task automatic drive(input logic r, input logic y, input logic g,
                         input logic clr);
        red = r;
        yellow = y;
        green = g;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with the sequencer holding red
        rst = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        expect_all("reset", 3, 0, 0, 0, 0, 0, 0, 0, 0);

        // Legal sequence R,Y,G,R,Y,G,R
        rst = 1'b1;
        drive(1, 0, 0, 0); expect_all("leg_r1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0); expect_all("leg_y1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0); expect_all("leg_g1", 2, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0); expect_all("leg_r2", 0, 1, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 1, 0, 0); expect_all("leg_y2", 1, 1, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 1, 0); expect_all("leg_g2", 2, 1, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0); expect_all("leg_r3", 0, 1, 0, 0, 0, 0, 0, 2, 2);

        // Order error R -> G, then legal G -> R counts a cycle
        drive(0, 0, 1, 0); expect_all("ord_g", 2, 0, 0, 1, 0, 0, 0, 2, 2);
        drive(1, 0, 0, 0); expect_all("ord_r", 0, 1, 0, 1, 0, 0, 0, 3, 3);

        // One-hot violation mid-sequence, then resync
        drive(0, 1, 0, 0); expect_all("oh_y", 1, 1, 0, 1, 0, 0, 0, 3, 3);
        drive(1, 0, 1, 0); expect_all("oh_rg", 3, 0, 1, 1, 0, 0, 0, 3, 3);
        drive(1, 0, 0, 0); expect_all("oh_r", 0, 0, 1, 1, 0, 0, 0, 3, 3);
        drive(0, 1, 0, 0); expect_all("oh_y2", 1, 1, 1, 1, 0, 0, 0, 3, 3);

        // clr_err alone clears every flag
        drive(0, 0, 1, 1); expect_all("clr_g", 2, 1, 0, 0, 0, 0, 0, 3, 3);
        drive(1, 0, 0, 0); expect_all("clr_r", 0, 1, 0, 0, 0, 0, 0, 4, 3);

        // Dwell: yellow held 3 samples; only MAX_DWELL=1 instances flag
        drive(0, 1, 0, 0); expect_all("dw_y1", 1, 1, 0, 0, 0, 0, 0, 4, 3);
        drive(0, 1, 0, 0); expect_all("dw_y2", 1, 1, 0, 0, 1, 0, 1, 4, 3);
        drive(0, 1, 0, 0); expect_all("dw_y3", 1, 1, 0, 0, 1, 0, 1, 4, 3);

        // Set wins over clear; dwell flag has no new set and clears
        drive(1, 0, 1, 1); expect_all("cs_rg", 3, 0, 1, 0, 0, 0, 0, 4, 3);
        drive(1, 0, 0, 1); expect_all("cs_r", 0, 0, 0, 0, 0, 0, 0, 4, 3);

        // Five full cycles: CNT_W=2 instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0);
            drive(0, 0, 1, 0);
            drive(1, 0, 0, 0);
        end
        expect_all("sat", 0, 1, 0, 0, 0, 0, 0, 9, 3);

        // Mid-YELLOW reset discards all history
        drive(0, 1, 0, 0); expect_all("pre_rst", 1, 1, 0, 0, 0, 0, 0, 9, 3);
        rst = 1'b0;
        drive(0, 1, 0, 0); expect_all("mid_rst", 3, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(1, 0, 0, 0); expect_all("post_r", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0); expect_all("post_y", 1, 1, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
# light_monitor

Passive checker on the traffic-light bus driven by the light-sequencing FSM. It samples the one-hot `red`/`yellow`/`green` outputs, decodes them to a phase code, and checks them against the legal order RED -> YELLOW -> GREEN -> RED, the one-hot rule, and a maximum dwell time. It reports sticky error flags and a count of completed light cycles to status/debug logic, and drives no signal back to the sequencer.

## Interface
- `CNT_W`, 16: width of `cycle_count` and of the internal dwell counter.
- `MAX_DWELL`, 1: maximum number of consecutive samples one phase may hold. Must be >= 1 and <= 2^CNT_W-1.

- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `red`  in  1: red light from the sequencer.
- `yellow`  in  1: yellow light from the sequencer.
- `green`  in  1: green light from the sequencer.
- `clr_err`  in  1: clears all sticky error flags, one-cycle pulse.
- `phase`  out  2: decoded phase of the last sample. 0 = RED, 1 = YELLOW, 2 = GREEN, 3 = INVALID.
- `locked`  out  1: monitor is tracking a legal sequence.
- `err_onehot`  out  1: sticky; a sample was not exactly one-hot (this includes all-off).
- `err_order`  out  1: sticky; a phase change skipped or reversed the order.
- `err_dwell`  out  1: sticky; a phase was held longer than `MAX_DWELL` samples.
- `cycle_count`  out  CNT_W: number of legal GREEN -> RED transitions. Saturates at all-ones.

## Operation
- Reset (`rst` = 0 at an edge) forces these values:
  - `phase` = 3, `locked` = 0, all `err_*` = 0, `cycle_count` = 0.
  - State = UNSYNC, dwell counter = 0.
- Each edge decodes the current inputs to `cur`. One-hot inputs give 0, 1 or 2; any other pattern gives 3. `cur` is compared with the `phase` register, which holds the previous sample. `phase` then loads `cur`.
- The state machine has two states, UNSYNC and TRACK.
- In UNSYNC:
  - `cur` = 3: stay in UNSYNC and set `err_onehot`.
  - `cur` valid: go to TRACK, set dwell to 1, no other checks. `locked` stays 0.
- In TRACK, one of four cases applies:
  - `cur` = 3: set `err_onehot`, go to UNSYNC, clear `locked`, set dwell to 0.
  - `cur` == `phase`: increment dwell, saturating. If the incremented value exceeds `MAX_DWELL`, set `err_dwell`. `locked` is unchanged.
  - `cur` == successor(`phase`), where successor is 0 -> 1 -> 2 -> 0: legal. Set `locked` = 1 and dwell = 1. If `phase` = 2 and `cur` = 0, increment `cycle_count`, saturating.
  - Any other valid `cur`: set `err_order`, clear `locked`, set dwell to 1, stay in TRACK and resynchronise on `cur`. `cycle_count` is not incremented.
- Sticky flags:
  - `clr_err` clears all three `err_*` at the edge.
  - If an error is detected at the same edge as `clr_err`, the set wins and that flag reads 1.
  - `clr_err` has no effect on `locked`, `phase` or `cycle_count`.
- Arithmetic: the dwell counter and `cycle_count` are unsigned CNT_W and never wrap.

## Timing
- All outputs are registered. An input change at edge k shows on `phase`, the flags, `locked` and `cycle_count` right after edge k, i.e. one cycle of latency.
- There is no handshake. One sample is taken per clock, and the inputs must be synchronous to `clk`.
- Reset mid-operation discards all history. The first sample after reset release is treated as an UNSYNC sample.
- Against the sequencer, which changes phase every cycle, `MAX_DWELL` = 1 checks strict one-cycle phases.
- Reset alignment with the sequencer:
  - During a shared reset the sequencer drives red = 1. The monitor ignores inputs while in reset.
  - The first post-reset RED sample enters TRACK without error.

## Structure
- Package `light_pkg`:
  - Phase constants `PH_RED`, `PH_YELLOW`, `PH_GREEN`, `PH_INVALID` and a 2-bit phase typedef.
  - State typedef for UNSYNC/TRACK.
  - Function `next_phase()`.
- Sub-module `light_decode`: combinational one-hot-to-phase decoder, also reusable by other status logic. Everything else lives in `light_monitor`.

## Test plan
- **Legal sequence:** `rst` low 3 cycles, then drive R,Y,G,R,Y,G,R on successive cycles.
  - Response: `phase` 0,1,2,0,1,2,0; `locked` = 1 from the second sample; `cycle_count` = 2; all `err_*` = 0.
- **One-hot violation:** drive red = green = 1 for one cycle mid-sequence.
  - Next cycle: `phase` = 3, `err_onehot` = 1, `locked` = 0.
  - Then drive R,Y: `locked` = 1 and `err_onehot` still 1.
- **Order error:** R then G.
  - Response: `err_order` = 1, `locked` = 0, `phase` = 2.
  - Then R: `locked` = 1 and `cycle_count` increments by 1.
- **Dwell:** `MAX_DWELL` = 1, hold yellow for 3 samples.
  - Response: `err_dwell` = 1 after the second yellow sample; no `err_order`.
  - Repeat with `MAX_DWELL` = 3: no error.
- **Clear vs set:**
  - `clr_err` together with a new one-hot violation: `err_onehot` stays 1.
  - `clr_err` alone: all flags 0 next cycle.
- **Saturation and mid-run reset:** `CNT_W` = 2, run 5 full cycles.
  - Response: `cycle_count` = 3.
  - Then assert `rst` = 0 for 1 cycle mid-YELLOW: all outputs return to their reset values.
